// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int WIDTH             = 32,
    parameter int DEPTH_BITS        = 3,
    parameter int PROG_FULL_THRESH  = 6,
    parameter int PROG_EMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CNT_W = DEPTH_BITS + 1;
    localparam int DEPTH = 2 ** DEPTH_BITS;

    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      PF_TH     = CNT_W'(PROG_FULL_THRESH);
    localparam logic [CNT_W-1:0]      PE_TH     = CNT_W'(PROG_EMPTY_THRESH);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
    localparam logic [DEPTH_BITS-1:0] PTR_ZERO  = DEPTH_BITS'(1'b0);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1'b1);

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  rd_ok_s;
    logic                  wr_ok_s;
    logic                  ovf_evt_s;
    logic                  unf_evt_s;
    logic [DEPTH_BITS-1:0] rd_ptr_nxt_s;
    logic [DEPTH_BITS-1:0] wr_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  overflow_nxt_s;
    logic                  underflow_nxt_s;

    // Status decode straight from the registered occupancy count.
    always_comb begin
        full_s  = (count_r == DEPTH_CNT);
        empty_s = (count_r == CNT_ZERO);
    end

    // Effective strobes: a write into a full FIFO is legal only alongside a pop.
    always_comb begin
        rd_ok_s   = rd_en & ~empty_s;
        wr_ok_s   = wr_en & (~full_s | rd_en);
        ovf_evt_s = wr_en & full_s & ~rd_en;
        unf_evt_s = rd_en & empty_s;
    end

    // Next-state computation for pointers, count and sticky error flags.
    always_comb begin
        rd_ptr_nxt_s    = rd_ptr_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        count_nxt_s     = count_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;

        if (rd_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (wr_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // A fresh error in the same cycle as err_clr must stay visible.
        if (ovf_evt_s) begin
            overflow_nxt_s = 1'b1;
        end else if (err_clr) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end

        if (unf_evt_s) begin
            underflow_nxt_s = 1'b1;
        end else if (err_clr) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r    <= PTR_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Storage array; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !reset) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Output mapping; dout is the current head with zero read latency.
    always_comb begin
        dout       = mem_r[rd_ptr_r];
        full       = full_s;
        empty      = empty_s;
        prog_full  = (count_r >= PF_TH);
        prog_empty = (count_r <= PE_TH);
        count      = count_r;
        overflow   = overflow_r;
        underflow  = underflow_r;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog using a queue scoreboard.
module tb_sync_fifo_prog;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic        err_clr;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic        prog_full;
    logic        prog_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks;
    int errors;

    logic [31:0] q_m [$];
    logic        ovf_m;
    logic        unf_m;

    sync_fifo_prog #(
        .WIDTH(32), .DEPTH_BITS(3), .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(1)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .err_clr(err_clr), .dout(dout), .full(full), .empty(empty),
        .prog_full(prog_full), .prog_empty(prog_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every status output against the scoreboard model.
    task automatic chk_all(input string tag);
        int n;
        n = q_m.size();
        chk({tag, ".count"}, {28'd0, count}, n);
        chk({tag, ".full"}, {31'd0, full}, {31'd0, (n == 8)});
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, (n == 0)});
        chk({tag, ".prog_full"}, {31'd0, prog_full}, {31'd0, (n >= 6)});
        chk({tag, ".prog_empty"}, {31'd0, prog_empty}, {31'd0, (n <= 1)});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ovf_m});
        chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, unf_m});
        if (n > 0) chk({tag, ".dout"}, dout, q_m[0]);
    endtask

    // One clock of stimulus; the model is advanced from its own pre-edge state.
    task automatic cycle(input logic wr, input logic rd, input logic [31:0] d,
                         input logic clr, input string tag);
        bit f, e, rok, wok;
        f   = (q_m.size() == 8);
        e   = (q_m.size() == 0);
        rok = rd && !e;
        wok = wr && (!f || rd);
        wr_en = wr; rd_en = rd; din = d; err_clr = clr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        if (rok) void'(q_m.pop_front());
        if (wok) q_m.push_back(d);
        if (wr && f && !rd) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
        if (rd && e) unf_m = 1'b1; else if (clr) unf_m = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        chk({tag, ".rst_count"}, {28'd0, count}, 32'd0);
        chk({tag, ".rst_empty"}, {31'd0, empty}, 32'd1);
        chk({tag, ".rst_full"}, {31'd0, full}, 32'd0);
        chk({tag, ".rst_pempty"}, {31'd0, prog_empty}, 32'd1);
        chk({tag, ".rst_pfull"}, {31'd0, prog_full}, 32'd0);
        chk({tag, ".rst_ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, ".rst_unf"}, {31'd0, underflow}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        ovf_m = 1'b0; unf_m = 1'b0;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 32'd0;
        @(posedge clk);
        #1;
        do_reset("t0");

        // Fill to full, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 32'(i), 1'b0, "t1_wr");
            chk("t1_count_step", {28'd0, count}, 32'(i));
            chk("t1_pfull_edge", {31'd0, prog_full}, {31'd0, (i >= 6)});
        end
        chk("t1_full", {31'd0, full}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("t1_dout_seq", dout, 32'(i));
            cycle(1'b0, 1'b1, 32'd0, 1'b0, "t1_rd");
        end
        chk("t1_empty", {31'd0, empty}, 32'd1);

        // Overflow on a full FIFO, then clear.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, "t2_fill");
        cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, "t2_ovf");
        chk("t2_ovf_set", {31'd0, overflow}, 32'd1);
        chk("t2_count8", {28'd0, count}, 32'd8);
        chk("t2_head", dout, 32'h100);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, "t2_clr");
        chk("t2_ovf_clr", {31'd0, overflow}, 32'd0);

        // Simultaneous write and read on a full FIFO.
        cycle(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, "t3_wr_rd");
        chk("t3_count8", {28'd0, count}, 32'd8);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_head", dout, 32'h101);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t3_last", dout, 32'hA5A5A5A5);
            cycle(1'b0, 1'b1, 32'd0, 1'b0, "t3_rd");
        end

        // Underflow on empty with a simultaneous accepted write.
        cycle(1'b1, 1'b1, 32'h12345678, 1'b0, "t4_wr_rd");
        chk("t4_unf", {31'd0, underflow}, 32'd1);
        chk("t4_count1", {28'd0, count}, 32'd1);
        chk("t4_dout", dout, 32'h12345678);
        cycle(1'b0, 1'b1, 32'd0, 1'b0, "t4_drain");
        // Error raised while clearing: the new error must survive.
        cycle(1'b0, 1'b1, 32'd0, 1'b1, "t4_set_wins");
        chk("t4_set_wins", {31'd0, underflow}, 32'd1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, "t4_clr");

        // Steady-state streaming across pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h200 + 32'(i), 1'b0, "t5_prime");
        for (int i = 3; i < 23; i++) begin
            chk("t5_order", dout, 32'h200 + 32'(i - 3));
            cycle(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, "t5_stream");
            chk("t5_count3", {28'd0, count}, 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'd0, 1'b0, "t5_drain");

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h300 + 32'(i), 1'b0, "t6_load");
        cycle(1'b1, 1'b1, 32'h399, 1'b0, "t6_pre");
        do_reset("t6");
        cycle(1'b1, 1'b0, 32'h55, 1'b0, "t6_wr");
        chk("t6_dout55", dout, 32'h55);
        cycle(1'b0, 1'b1, 32'd0, 1'b0, "t6_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
